mips_run_monitor: RTL
=====================

MIPS_RUN_MONITOR -- requirements
Module: mips_run_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 1, number of CPU channels monitored in parallel.
REQ-002 SHALL have parameter RESET_CYCLES, default 2, cycles cpu_reset is held after start.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 40, maximum RUN-state cycles.
REQ-004 SHALL have parameter CNT_W, default $clog2(TIMEOUT_CYCLES+1), cycle counter width.
REQ-005 SHALL have port: clk, in, 1, single clock, all logic on rising edge.
REQ-006 SHALL have port: reset, in, 1, synchronous, active-high.
REQ-007 SHALL have port: start, in, 1, begin-run request.
REQ-008 SHALL have port: cpu_reset, out, 1, reset driven to CPU(s).
REQ-009 SHALL have port: cpu_clk_enable, out, 1, clock enable driven to CPU(s).
REQ-010 SHALL have port: cpu_active, in, N_CH, per-channel CPU active.
REQ-011 SHALL have port: cpu_register_v0, in, 32*N_CH, per-channel v0, channel i at bits [32i+31:32i].
REQ-012 SHALL have ports: busy, out, 1; done, out, 1 (level until next run).
REQ-013 SHALL have ports: timed_out, out, 1; finished, out, N_CH; start_err, out, N_CH.
REQ-014 SHALL have ports: v0_captured, out, 32*N_CH; cycle_count, out, CNT_W.

Function
REQ-015 SHALL implement states IDLE, RESET, CHECK, RUN, DONE.
REQ-016 IDLE/DONE: start=1 at an edge -> RESET next cycle; clear done, timed_out, finished, start_err, v0_captured, cycle_count.
REQ-017 SHALL ignore start in RESET, CHECK, RUN.
REQ-018 RESET: cpu_reset=1 for exactly RESET_CYCLES cycles, then -> CHECK with cpu_reset=0.
REQ-019 CHECK (one cycle): channel i with cpu_active[i]=0 -> start_err[i]=1 and finished[i]=1; if all finished -> DONE, else -> RUN with cycle_count=0.
REQ-020 RUN: cycle_count increments by 1 every edge.
REQ-021 RUN: unfinished channel i sampled with cpu_active[i]=0 -> finished[i]=1, v0_captured[i]=cpu_register_v0[i] at that same edge; later changes ignored.
REQ-022 RUN: all channels finished (including this edge) -> DONE, timed_out=0.
REQ-023 RUN: otherwise, if cycle_count+1==TIMEOUT_CYCLES -> DONE, timed_out=1; unfinished channels keep finished=0.
REQ-024 Simultaneous last-finish and timeout edge: finish wins, timed_out=0.
REQ-025 cpu_reset=1 in IDLE and RESET, 0 otherwise.
REQ-026 cpu_clk_enable=1 in RESET, CHECK, RUN; 0 in IDLE and DONE (CPU frozen).
REQ-027 busy=1 in RESET, CHECK, RUN; done=1 in DONE only.
REQ-028 cycle_count SHALL hold its value in DONE and never exceed TIMEOUT_CYCLES.

Reset
REQ-029 reset=1 at an edge -> IDLE from any state, including mid-run.
REQ-030 Reset values: cpu_reset=1, cpu_clk_enable=0, busy=0, done=0, timed_out=0, finished=0, start_err=0, v0_captured=0, cycle_count=0.
REQ-031 start coincident with reset SHALL be ignored.

Configuration
REQ-032 Macro RUN_MONITOR_EXPECT_EN SHALL add input expected_v0 (32*N_CH) and output pass (N_CH).
REQ-033 With macro: pass[i]=1 iff finished[i]=1, start_err[i]=0, and captured v0 equals expected_v0[i] sampled at capture edge; pass resets/clears to 0.
REQ-034 Without macro: neither port exists; all other behaviour identical.

Verification
REQ-035 N_CH=1, RESET_CYCLES=2, TIMEOUT_CYCLES=40; start; model drops active at 10th RUN edge with v0=0x00000005 -> done=1, timed_out=0, finished=1, v0_captured=0x5, cycle_count=10, cpu_clk_enable=0.
REQ-036 Same config, active never drops -> DONE after 40 RUN cycles, timed_out=1, finished=0, cycle_count=40.
REQ-037 active=0 in CHECK cycle -> start_err=1, finished=1, done=1 next cycle, cycle_count=0.
REQ-038 N_CH=2: ch0 finishes at RUN edge 5 (v0=0xA), ch1 at edge 40 (v0=0xB) -> timed_out=0, v0_captured={0xB,0xA}, cycle_count=40.
REQ-039 reset pulsed at RUN edge 7 -> next cycle all outputs at reset values, cpu_reset=1; start during RUN has no effect.
REQ-040 With RUN_MONITOR_EXPECT_EN: expected 0x5, v0 0x5 -> pass=1; expected 0x6 -> pass=0; timed-out channel -> pass=0.

Source files
------------

// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - resets, runs and watches N_CH CPUs until each drops cpu_active or a cycle limit hits.
// Optional macro RUN_MONITOR_EXPECT_EN adds expected_v0 input and per-channel pass output.
module mips_run_monitor #(
  parameter int N_CH           = 1,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 cpu_reset,
  output logic                 cpu_clk_enable,
  input  logic [N_CH-1:0]      cpu_active,
  input  logic [32*N_CH-1:0]   cpu_register_v0,
`ifdef RUN_MONITOR_EXPECT_EN
  input  logic [32*N_CH-1:0]   expected_v0,
  output logic [N_CH-1:0]      pass,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [N_CH-1:0]      finished,
  output logic [N_CH-1:0]      start_err,
  output logic [32*N_CH-1:0]   v0_captured,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_CHECK, S_RUN, S_DONE} state_t;

  state_t          state, state_next;
  logic [RC_W-1:0] rst_cnt;
  logic [N_CH-1:0] newly;
  logic            all_fin;

  // finished is cleared at start, so the same terms serve both CHECK and RUN
  assign newly   = ~finished & ~cpu_active;
  assign all_fin = &(finished | ~cpu_active);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    cpu_reset      = 1'b0;
    cpu_clk_enable = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_reset = 1'b1;
        if (start) state_next = S_RESET;
      end
      S_RESET: begin
        cpu_reset      = 1'b1;
        cpu_clk_enable = 1'b1;
        busy           = 1'b1;
        if (rst_cnt == RC_LAST) state_next = S_CHECK;
      end
      S_CHECK: begin
        cpu_clk_enable = 1'b1;
        busy           = 1'b1;
        state_next     = all_fin ? S_DONE : S_RUN;
      end
      S_RUN: begin
        cpu_clk_enable = 1'b1;
        busy           = 1'b1;
        if (all_fin || cycle_count == TO_LAST) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_RESET;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt     <= '0;
      timed_out   <= 1'b0;
      finished    <= '0;
      start_err   <= '0;
      v0_captured <= '0;
      cycle_count <= '0;
`ifdef RUN_MONITOR_EXPECT_EN
      pass        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rst_cnt     <= '0;
            timed_out   <= 1'b0;
            finished    <= '0;
            start_err   <= '0;
            v0_captured <= '0;
            cycle_count <= '0;
`ifdef RUN_MONITOR_EXPECT_EN
            pass        <= '0;
`endif
          end
        end
        S_RESET: begin
          if (rst_cnt != RC_LAST) rst_cnt <= rst_cnt + 1'b1;
        end
        S_CHECK: begin
          start_err   <= ~cpu_active;
          finished    <= ~cpu_active;
          cycle_count <= '0;
        end
        S_RUN: begin
          cycle_count <= cycle_count + 1'b1;
          for (int i = 0; i < N_CH; i++) begin
            if (newly[i]) begin
              finished[i]             <= 1'b1;
              v0_captured[32*i +: 32] <= cpu_register_v0[32*i +: 32];
`ifdef RUN_MONITOR_EXPECT_EN
              pass[i] <= (cpu_register_v0[32*i +: 32] == expected_v0[32*i +: 32]);
`endif
            end
          end
          // a channel finishing on the limit edge takes priority over the timeout
          if (!all_fin && cycle_count == TO_LAST) timed_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
